// File: rtl/rom_reader_pkg.sv
// Shared definitions for rom_burst_reader: FSM state encoding and default widths.
package rom_reader_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 8;
    localparam int DEFAULT_DATA_WIDTH = 8;

    // IDLE waits for start, REQ presents the read to the ROM, WAIT captures
    // the ROM data, OUT holds the byte until the sink takes it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } state_t;

endpackage

// File: rtl/rom_burst_reader.sv
// rom_burst_reader: read initiator for a single-port synchronous ROM.
// Accepts a start address and burst length, issues one registered ROM read
// per byte (rom_cs high for exactly one cycle), captures the data at the edge
// after the ROM sampled the request and streams it out on valid/ready.
// Optional feature macro: ROM_READER_CHECKSUM_EN adds a running byte checksum
// of the handshaked output bytes on the checksum port.
module rom_burst_reader
    import rom_reader_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH-1:0] burst_len,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  rom_cs,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0] rom_dout
`ifdef ROM_READER_CHECKSUM_EN
    ,
    output logic [DATA_WIDTH-1:0] checksum
`endif
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;

    state_t                  state_reg,     state_next;
    logic [ADDR_WIDTH-1:0]   remaining_reg, remaining_next;
    logic [ADDR_WIDTH-1:0]   rom_addr_reg,  rom_addr_next;
    logic                    rom_cs_reg,    rom_cs_next;
    logic [DATA_WIDTH-1:0]   m_data_reg,    m_data_next;
    logic                    m_valid_reg,   m_valid_next;
    logic                    busy_reg,      busy_next;
    logic                    done_reg,      done_next;
`ifdef ROM_READER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0]   checksum_reg,  checksum_next;
`endif

    // State and output registers; reset abandons any burst immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            remaining_reg <= '0;
            rom_addr_reg  <= '0;
            rom_cs_reg    <= 1'b0;
            m_data_reg    <= '0;
            m_valid_reg   <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
`ifdef ROM_READER_CHECKSUM_EN
            checksum_reg  <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
            rom_addr_reg  <= rom_addr_next;
            rom_cs_reg    <= rom_cs_next;
            m_data_reg    <= m_data_next;
            m_valid_reg   <= m_valid_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
`ifdef ROM_READER_CHECKSUM_EN
            checksum_reg  <= checksum_next;
`endif
        end
    end

    // Next-state and next-output logic; rom_addr doubles as the burst address
    // counter since it must hold steady through REQ/WAIT/OUT anyway.
    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        rom_addr_next  = rom_addr_reg;
        rom_cs_next    = rom_cs_reg;
        m_data_next    = m_data_reg;
        m_valid_next   = m_valid_reg;
        busy_next      = busy_reg;
        done_next      = 1'b0;
`ifdef ROM_READER_CHECKSUM_EN
        checksum_next  = checksum_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (start) begin
                    remaining_next = burst_len;
                    rom_addr_next  = start_addr;
                    rom_cs_next    = 1'b1;
                    busy_next      = 1'b1;
`ifdef ROM_READER_CHECKSUM_EN
                    checksum_next  = '0;
`endif
                    state_next     = REQ;
                end
            end
            REQ: begin
                // The ROM samples cs/addr on this edge; drop the select.
                rom_cs_next = 1'b0;
                state_next  = WAIT;
            end
            WAIT: begin
                // Data became valid after the previous falling edge and is
                // still stable at this rising edge.
                m_data_next  = rom_dout;
                m_valid_next = 1'b1;
                state_next   = OUT;
            end
            OUT: begin
                if (m_ready) begin
                    m_valid_next  = 1'b0;
`ifdef ROM_READER_CHECKSUM_EN
                    checksum_next = checksum_reg + m_data_reg;
`endif
                    if (remaining_reg == '0) begin
                        done_next  = 1'b1;
                        busy_next  = 1'b0;
                        state_next = IDLE;
                    end else begin
                        remaining_next = remaining_reg - ADDR_ONE;
                        rom_addr_next  = rom_addr_reg + ADDR_ONE;
                        rom_cs_next    = 1'b1;
                        state_next     = REQ;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy     = busy_reg;
    assign done     = done_reg;
    assign m_data   = m_data_reg;
    assign m_valid  = m_valid_reg;
    assign rom_cs   = rom_cs_reg;
    assign rom_addr = rom_addr_reg;
`ifdef ROM_READER_CHECKSUM_EN
    assign checksum = checksum_reg;
`endif

endmodule

// File: tb/tb_rom_burst_reader.sv
// Testbench for rom_burst_reader. Models the synchronous ROM (sample at the
// rising edge, data after the falling edge, garbage after the hold time) and
// checks byte streams, read addresses, timing, backpressure and resets.
// Checksum checks are compiled when ROM_READER_CHECKSUM_EN is defined.
module tb_rom_burst_reader;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] start_addr;
    logic [7:0] burst_len;
    logic       busy;
    logic       done;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic       rom_cs;
    logic [7:0] rom_addr;
    logic [7:0] rom_dout;
`ifdef ROM_READER_CHECKSUM_EN
    logic [7:0] checksum;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] rom_mem [256];
    logic [7:0] reads_q [$];
    logic       cs_prev = 1'b0;
    logic [7:0] rom_lat;

    always #5 clk = ~clk;

    rom_burst_reader #(
        .ADDR_WIDTH(8),
        .DATA_WIDTH(8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .start_addr(start_addr),
        .burst_len (burst_len),
        .busy      (busy),
        .done      (done),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .rom_cs    (rom_cs),
        .rom_addr  (rom_addr),
        .rom_dout  (rom_dout)
`ifdef ROM_READER_CHECKSUM_EN
        ,
        .checksum  (checksum)
`endif
    );

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // ROM model: sample at rising edge, drive data after the falling edge,
    // corrupt it just after the following rising edge (hold time over).
    initial begin
        rom_dout = 8'h00;
        forever begin
            @(posedge clk);
            if (rom_cs === 1'b1) begin
                rom_lat = rom_addr;
                #1 rom_dout = rom_mem[rom_lat] ^ 8'hC3;
                @(negedge clk);
                rom_dout = rom_mem[rom_lat];
                @(posedge clk);
                #1 rom_dout = rom_mem[rom_lat] ^ 8'hFF;
            end
        end
    end

    // Read monitor: log every issued ROM read and flag back-to-back selects.
    always @(posedge clk) begin
        if (rom_cs === 1'b1) begin
            reads_q.push_back(rom_addr);
            check("rom_cs_one_cycle", {31'd0, cs_prev}, 32'd0);
        end
        cs_prev <= rom_cs;
    end

    // One burst with optional stall and a start pulse while busy; expected
    // bytes and addresses come from rom_mem[(addr + i) mod 256].
    task automatic run_burst(input logic [7:0] addr, input logic [7:0] len,
                             input int stall_idx, input int stall_len,
                             input int poke_idx, input int exp_cycles);
        int         cyc;
        int         waits;
        logic [7:0] idx;
        logic [7:0] exp_b;
        logic [7:0] sum;
        cyc = 0;
        sum = 8'h00;
        reads_q.delete();
        m_ready    = 1'b1;
        start      = 1'b1;
        start_addr = addr;
        burst_len  = len;
        @(posedge clk); #1;
        start      = 1'b0;
        start_addr = 8'($urandom);
        burst_len  = 8'($urandom);
        check("accept_busy", {31'd0, busy}, 32'd1);
        check("accept_rom_cs", {31'd0, rom_cs}, 32'd1);
        check("accept_rom_addr", {24'd0, rom_addr}, {24'd0, addr});
        check("accept_done_low", {31'd0, done}, 32'd0);
`ifdef ROM_READER_CHECKSUM_EN
        check("accept_checksum_clear", {24'd0, checksum}, 32'd0);
`endif
        for (int i = 0; i <= int'(len); i++) begin
            waits = 0;
            while (m_valid !== 1'b1 && waits < 20) begin
                @(posedge clk); #1;
                waits++;
                cyc++;
            end
            if (m_valid !== 1'b1) begin
                check("m_valid_timeout", {31'd0, m_valid}, 32'd1);
                return;
            end
            check("valid_latency", waits, 32'd2);
            idx   = addr + 8'(i);
            exp_b = rom_mem[idx];
            check("m_data", {24'd0, m_data}, {24'd0, exp_b});
            sum = sum + exp_b;
            if (i == poke_idx) begin
                start      = 1'b1;
                start_addr = 8'h40;
                burst_len  = 8'h05;
            end
            if (i == stall_idx) begin
                m_ready = 1'b0;
                repeat (stall_len) begin
                    @(posedge clk); #1;
                    cyc++;
                    check("stall_valid", {31'd0, m_valid}, 32'd1);
                    check("stall_data", {24'd0, m_data}, {24'd0, exp_b});
                    check("stall_rom_cs", {31'd0, rom_cs}, 32'd0);
                end
                m_ready = 1'b1;
            end
            @(posedge clk); #1;
            cyc++;
            start = 1'b0;
            check("valid_drop", {31'd0, m_valid}, 32'd0);
            if (i == int'(len)) begin
                check("done_pulse", {31'd0, done}, 32'd1);
                check("busy_end", {31'd0, busy}, 32'd0);
                check("rom_cs_end", {31'd0, rom_cs}, 32'd0);
`ifdef ROM_READER_CHECKSUM_EN
                check("checksum", {24'd0, checksum}, {24'd0, sum});
`endif
            end else begin
                idx = addr + 8'(i + 1);
                check("done_mid", {31'd0, done}, 32'd0);
                check("busy_mid", {31'd0, busy}, 32'd1);
                check("next_rom_cs", {31'd0, rom_cs}, 32'd1);
                check("next_rom_addr", {24'd0, rom_addr}, {24'd0, idx});
            end
        end
        check("burst_cycles", cyc, exp_cycles);
        check("read_count", reads_q.size(), int'(len) + 1);
        for (int i = 0; i < reads_q.size() && i <= int'(len); i++) begin
            idx = addr + 8'(i);
            check("read_addr", {24'd0, reads_q[i]}, {24'd0, idx});
        end
        $display("burst addr=0x%02h len=%0d stall=%0d/%0d poke=%0d cycles=%0d", addr, len, stall_idx, stall_len, poke_idx, cyc);
    endtask

    typedef struct {
        logic [7:0] addr;
        logic [7:0] len;
        int         stall_idx;
        int         stall_len;
        int         poke_idx;
        int         exp_cycles;
    } vec_t;

    vec_t vecs [6];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int len_r;
        int stall_r;
        int slen_r;
        for (int i = 0; i < 256; i++) rom_mem[i] = 8'($urandom);
        rom_mem[8'h00] = 8'h01;
        rom_mem[8'h01] = 8'h02;
        rom_mem[8'h02] = 8'h03;
        rom_mem[8'h03] = 8'hFF;
        rom_mem[8'h10] = 8'hA5;

        //             addr   len   stall stall_len poke cycles
        vecs[0] = '{8'h10, 8'd0, -1, 0, -1,  3};
        vecs[1] = '{8'hFE, 8'd3, -1, 0, -1, 12};
        vecs[2] = '{8'h20, 8'd3,  1, 5, -1, 17};
        vecs[3] = '{8'h60, 8'd3, -1, 0,  1, 12};
        vecs[4] = '{8'h00, 8'd3, -1, 0, -1, 12};
        vecs[5] = '{8'h80, 8'd7,  7, 2,  3, 26};

        rst        = 1'b1;
        start      = 1'b0;
        start_addr = 8'h00;
        burst_len  = 8'h00;
        m_ready    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_rom_cs", {31'd0, rom_cs}, 32'd0);
        check("reset_rom_addr", {24'd0, rom_addr}, 32'd0);
        check("reset_m_valid", {31'd0, m_valid}, 32'd0);
        check("reset_m_data", {24'd0, m_data}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_done", {31'd0, done}, 32'd0);
`ifdef ROM_READER_CHECKSUM_EN
        check("reset_checksum", {24'd0, checksum}, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int v = 0; v < 6; v++) begin
            run_burst(vecs[v].addr, vecs[v].len, vecs[v].stall_idx,
                      vecs[v].stall_len, vecs[v].poke_idx, vecs[v].exp_cycles);
        end

        // Reset while the request is on the ROM port: select drops at once.
        start = 1'b1; start_addr = 8'h33; burst_len = 8'd2;
        @(posedge clk); #1;
        start = 1'b0;
        check("req_cs_before_rst", {31'd0, rom_cs}, 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rst_req_rom_cs", {31'd0, rom_cs}, 32'd0);
        check("rst_req_busy", {31'd0, busy}, 32'd0);
        @(negedge clk); rst = 1'b0;

        // Reset in WAIT.
        @(negedge clk);
        start = 1'b1; start_addr = 8'h44; burst_len = 8'd2;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("rst_wait_rom_cs", {31'd0, rom_cs}, 32'd0);
        check("rst_wait_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_wait_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;
        check("rst_held_m_valid", {31'd0, m_valid}, 32'd0);
        @(negedge clk); rst = 1'b0;

        // Reset while a byte is stalled in OUT: byte lost, no done.
        @(negedge clk);
        m_ready = 1'b0;
        start = 1'b1; start_addr = 8'h50; burst_len = 8'd1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("out_valid_before_rst", {31'd0, m_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("rst_out_m_valid", {31'd0, m_valid}, 32'd0);
        check("rst_out_m_data", {24'd0, m_data}, 32'd0);
        check("rst_out_busy", {31'd0, busy}, 32'd0);
        @(negedge clk); rst = 1'b0; m_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check("no_done_after_rst", {31'd0, done}, 32'd0);
            check("idle_after_rst_rom_cs", {31'd0, rom_cs}, 32'd0);
        end
        @(negedge clk);
        run_burst(8'h00, 8'd3, -1, 0, -1, 12);

        // Randomized bursts against the reference model.
        for (int r = 0; r < 20; r++) begin
            len_r   = int'($urandom_range(0, 6));
            stall_r = ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, len_r)) : -1;
            slen_r  = (stall_r >= 0) ? int'($urandom_range(1, 4)) : 0;
            run_burst(8'($urandom), 8'(len_r), stall_r, slen_r,
                      ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len_r)) : -1,
                      3 * (len_r + 1) + slen_r);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
